// File: rtl/rr_arbiter16.sv
// 16-way arbiter with round-robin or fixed-priority selection.
// A grant is held until the owner pulses done, drops its request, or the
// hold counter reaches MAX_HOLD. A one-cycle GAP always follows a grant.
// Every output comes straight from a flop.
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        prio_mode,
  input  logic [15:0] req,
  input  logic        done,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant_onehot,
  output logic        busy,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ptr_reg, ptr_next;
  logic [7:0]  hold_reg, hold_next;
  logic        valid_reg, valid_next;
  logic [3:0]  idx_reg, idx_next;
  logic [15:0] onehot_reg, onehot_next;
  logic        busy_reg, busy_next;
  logic        tflag_reg, tflag_next;

  logic [15:0] rot_req;
  logic [3:0]  rr_off;
  logic [3:0]  fp_win;
  logic [3:0]  winner;
  logic        start;
  logic [7:0]  hold_inc;
  logic        hold_hit;
  logic        release_normal;
  logic        release_any;
  logic        timeout_evt;

  // rot_req[k] is the request of requester (ptr + k) mod 16, so the lowest
  // set bit of rot_req is the round-robin winner relative to ptr.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rot
      logic [3:0] pos;
      assign pos         = ptr_reg + 4'(gi);
      assign rot_req[gi] = req[pos];
    end
  endgenerate

  // Winner selection for both modes; fixed priority ignores ptr.
  always_comb begin
    rr_off = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (rot_req[k]) rr_off = 4'(k);
    end
    fp_win = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (req[k]) fp_win = 4'(k);
    end
    winner = prio_mode ? fp_win : (ptr_reg + rr_off);
  end

  assign start          = ena && (req != 16'd0);
  assign hold_inc       = hold_reg + 8'd1;
  assign hold_hit       = (hold_inc == 8'(MAX_HOLD));
  assign release_normal = done || !req[idx_reg];
  assign release_any    = release_normal || hold_hit;
  // A timeout only counts when nothing else would have released the grant.
  assign timeout_evt    = hold_hit && !release_normal;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (release_any) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    hold_next  = hold_reg;
    tflag_next = tflag_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next  = winner;
          hold_next = 8'd0;
        end
      end
      BUSY: begin
        hold_next = hold_inc;
        if (release_any) ptr_next = idx_reg + 4'd1;
        if (timeout_evt) tflag_next = 1'b1;
      end
      default: ;
    endcase
    valid_next  = (state_next == BUSY);
    onehot_next = valid_next ? (16'd1 << idx_next) : 16'd0;
    busy_next   = (state_next != IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg    <= 4'd0;
      hold_reg   <= 8'd0;
      valid_reg  <= 1'b0;
      idx_reg    <= 4'd0;
      onehot_reg <= 16'd0;
      busy_reg   <= 1'b0;
      tflag_reg  <= 1'b0;
    end else begin
      ptr_reg    <= ptr_next;
      hold_reg   <= hold_next;
      valid_reg  <= valid_next;
      idx_reg    <= idx_next;
      onehot_reg <= onehot_next;
      busy_reg   <= busy_next;
      tflag_reg  <= tflag_next;
    end
  end

  assign grant_valid  = valid_reg;
  assign grant_idx    = idx_reg;
  assign grant_onehot = onehot_reg;
  assign busy         = busy_reg;
  assign timeout_flag = tflag_reg;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: a behavioural model predicts every cycle's outputs
// and every completed grant; a monitor compares them against the DUT.
module tb_rr_arbiter16;
  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        prio_mode = 1'b0;
  logic [15:0] req = 16'd0;
  logic        done = 1'b0;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic        busy;
  logic        timeout_flag;

  rr_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .prio_mode    (prio_mode),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  idx;
    logic [15:0] onehot;
    logic        busy;
    logic        tflag;
  } cyc_t;

  typedef struct {
    int idx;
    int len;
  } gnt_t;

  cyc_t cyc_q[$];
  gnt_t gnt_q[$];
  int   grant_log[$];
  int   len_log[$];

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;
  bit prev_valid = 1'b0;
  int cur_len = 0;
  int low_cnt = 0;
  bit seen_grant = 1'b0;

  // Model: 0 = idle, 1 = granted, 2 = gap
  int m_phase = 0;
  int m_ptr = 0;
  int m_idx = 0;
  int m_hold = 0;
  bit m_tflag = 1'b0;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // One clock of the arbiter rules, applied to the inputs present at the edge.
  task automatic model_step(input logic e, input logic pm, input logic [15:0] r, input logic d);
    cyc_t c;
    gnt_t g;
    int w;
    case (m_phase)
      0: begin
        if (e && r != 16'd0) begin
          w = 0;
          if (pm) begin
            for (int i = 0; i < 16; i++) if (r[i]) w = i;
          end else begin
            for (int k = 15; k >= 0; k--) if (r[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
          end
          m_idx = w;
          m_hold = 0;
          m_phase = 1;
        end
      end
      1: begin
        m_hold++;
        if (d || !r[m_idx] || m_hold == MAX_HOLD) begin
          if (!d && r[m_idx]) m_tflag = 1'b1;
          g.idx = m_idx;
          g.len = m_hold;
          gnt_q.push_back(g);
          m_ptr = (m_idx + 1) % 16;
          m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
    c.valid  = (m_phase == 1);
    c.idx    = 4'(m_idx);
    c.onehot = c.valid ? (16'd1 << m_idx) : 16'd0;
    c.busy   = (m_phase != 0);
    c.tflag  = m_tflag;
    cyc_q.push_back(c);
  endtask

  // Called at a negedge; applies inputs for the next rising edge, ends at the next negedge.
  task automatic drive(input logic e, input logic pm, input logic [15:0] r, input logic d);
    ena = e;
    prio_mode = pm;
    req = r;
    done = d;
    model_step(e, pm, r, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; releases reset on a negedge.
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    ena = 1'b0;
    req = 16'd0;
    done = 1'b0;
    prio_mode = 1'b0;
    repeat (2) @(negedge clk);
    cyc_q.delete();
    gnt_q.delete();
    grant_log.delete();
    len_log.delete();
    prev_valid = 1'b0;
    seen_grant = 1'b0;
    low_cnt = 0;
    m_phase = 0;
    m_ptr = 0;
    m_idx = 0;
    m_hold = 0;
    m_tflag = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, grant_valid === 1'b0, $sformatf("got %b want 0", grant_valid));
    check({tag, "_idx"}, grant_idx === 4'd0, $sformatf("got %0d want 0", grant_idx));
    check({tag, "_onehot"}, grant_onehot === 16'd0, $sformatf("got %h want 0000", grant_onehot));
    check({tag, "_busy"}, busy === 1'b0, $sformatf("got %b want 0", busy));
    check({tag, "_tflag"}, timeout_flag === 1'b0, $sformatf("got %b want 0", timeout_flag));
  endtask

  // Monitor: per-cycle output comparison plus grant-level scoreboard.
  always @(posedge clk) begin : mon
    cyc_t c;
    gnt_t g;
    #1;
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        check("cycle_expect", 1'b0, "no expectation queued");
      end else begin
        c = cyc_q.pop_front();
        check("cycle",
              grant_valid === c.valid && grant_idx === c.idx && grant_onehot === c.onehot &&
              busy === c.busy && timeout_flag === c.tflag,
              $sformatf("got v=%b i=%0d oh=%h b=%b t=%b want v=%b i=%0d oh=%h b=%b t=%b",
                        grant_valid, grant_idx, grant_onehot, busy, timeout_flag,
                        c.valid, c.idx, c.onehot, c.busy, c.tflag));
      end
      if (grant_valid && !prev_valid) begin
        if (seen_grant)
          check("grant_spacing", low_cnt >= 2, $sformatf("got %0d idle cycles want >=2", low_cnt));
        seen_grant = 1'b1;
        grant_log.push_back(int'(grant_idx));
        cur_len = 1;
      end else if (grant_valid) begin
        cur_len++;
      end else if (prev_valid) begin
        len_log.push_back(cur_len);
        if (gnt_q.size() == 0) begin
          check("grant_expect", 1'b0, "grant ended with none predicted");
        end else begin
          g = gnt_q.pop_front();
          check("grant", int'(grant_idx) == g.idx && cur_len == g.len,
                $sformatf("got idx=%0d len=%0d want idx=%0d len=%0d",
                          grant_idx, cur_len, g.idx, g.len));
        end
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      prev_valid = grant_valid;
    end
  end

  initial begin
    int exp_rr[4];
    int base;
    logic [15:0] r;
    logic e;
    logic pm;
    logic d;
    exp_rr = '{0, 3, 0, 3};

    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    do_reset();

    // Round-robin rotation between 0 and 3
    repeat (12) drive(1'b1, 1'b0, 16'h0009, 1'b1);
    check("rr_count", grant_log.size() >= 4, $sformatf("got %0d grants want >=4", grant_log.size()));
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size())
        check($sformatf("rr_seq%0d", i), grant_log[i] == exp_rr[i],
              $sformatf("got %0d want %0d", grant_log[i], exp_rr[i]));
    end
    repeat (3) drive(1'b1, 1'b0, 16'h0000, 1'b0);

    // Fixed priority always picks 15
    base = grant_log.size();
    repeat (12) drive(1'b1, 1'b1, 16'h8001, 1'b1);
    check("fp_count", grant_log.size() - base >= 4,
          $sformatf("got %0d grants want >=4", grant_log.size() - base));
    for (int i = base; i < grant_log.size(); i++)
      check("fp_idx", grant_log[i] == 15, $sformatf("got %0d want 15", grant_log[i]));
    repeat (3) drive(1'b1, 1'b0, 16'h0000, 1'b0);

    // Timeout: 4 busy cycles, flag set, requester 5 regranted after GAP+IDLE
    do_reset();
    repeat (10) drive(1'b1, 1'b0, 16'h0020, 1'b0);
    check("to_len", len_log.size() >= 1 && len_log[0] == 4,
          $sformatf("got %0d want 4", (len_log.size() >= 1) ? len_log[0] : -1));
    check("to_flag", timeout_flag === 1'b1, $sformatf("got %b want 1", timeout_flag));
    check("to_regrant", grant_log.size() == 2 && grant_log[1] == 5,
          $sformatf("got %0d grants last=%0d want 2 grants last=5",
                    grant_log.size(), (grant_log.size() > 0) ? grant_log[grant_log.size()-1] : -1));
    repeat (3) drive(1'b1, 1'b0, 16'h0000, 1'b0);

    // done coinciding with the hold limit is a normal release; ptr moves to 6
    do_reset();
    repeat (4) drive(1'b1, 1'b0, 16'h0020, 1'b0);
    drive(1'b1, 1'b0, 16'h0020, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 16'h0041, 1'b0);
    check("sim_flag", timeout_flag === 1'b0, $sformatf("got %b want 0", timeout_flag));
    check("sim_ptr", grant_log.size() == 2 && grant_log[1] == 6,
          $sformatf("got %0d grants last=%0d want 2 grants last=6",
                    grant_log.size(), (grant_log.size() > 0) ? grant_log[grant_log.size()-1] : -1));
    repeat (3) drive(1'b1, 1'b0, 16'h0000, 1'b0);

    // Wrap from 15 and ena gating
    base = grant_log.size();
    drive(1'b1, 1'b1, 16'h8002, 1'b0);
    drive(1'b0, 1'b1, 16'h8002, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 16'h8002, 1'b0);
    check("gate_none", grant_log.size() == base + 1,
          $sformatf("got %0d grants want %0d", grant_log.size() - base, 1));
    drive(1'b1, 1'b0, 16'h8002, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("wrap_idx", grant_log.size() == base + 2 && grant_log[base+1] == 1,
          $sformatf("got %0d grants last=%0d want last=1",
                    grant_log.size() - base, (grant_log.size() > 0) ? grant_log[grant_log.size()-1] : -1));

    // Randomised traffic
    r = 16'h0000;
    pm = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: r = 16'h0000;
          1: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
          2: r = 16'd1 << $urandom_range(0, 15);
          default: r = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 49) == 0) pm = ~pm;
      e = ($urandom_range(0, 9) != 0);
      d = ($urandom_range(0, 5) == 0);
      drive(e, pm, r, d);
    end

    // Reset during a grant drops everything at once; first grant after uses ptr=0
    repeat (3) drive(1'b1, 1'b0, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 16'hFFFF, 1'b0);
    check("pre_reset_valid", grant_valid === 1'b1, $sformatf("got %b want 1", grant_valid));
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    do_reset();
    drive(1'b1, 1'b0, 16'hFFFF, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 16'h0000, 1'b0);
    check("post_reset_idx", grant_log.size() >= 1 && grant_log[0] == 0,
          $sformatf("got %0d want 0", (grant_log.size() > 0) ? grant_log[0] : -1));
    check("queues_drained", cyc_q.size() == 0 && gnt_q.size() == 0,
          $sformatf("got %0d/%0d pending want 0/0", cyc_q.size(), gnt_q.size()));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 255: maximum number of BUSY cycles per grant, range 1..255.
REQ-002 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL provide port ena, input, 1: when 0, no new grant is issued.
REQ-005 SHALL provide port prio_mode, input, 1: 0 = round-robin, 1 = fixed priority (highest index wins).
REQ-006 SHALL provide port req, input, 16: request lines; bit i belongs to requester i.
REQ-007 SHALL provide port done, input, 1: single-cycle release pulse from the granted requester.
REQ-008 SHALL provide port grant_valid, output, 1: a grant is active.
REQ-009 SHALL provide port grant_idx, output, 4: index of the granted requester.
REQ-010 SHALL provide port grant_onehot, output, 16: one-hot copy of the grant; all zeros when grant_valid=0.
REQ-011 SHALL provide port busy, output, 1: state is not IDLE.
REQ-012 SHALL provide port timeout_flag, output, 1: sticky; set when a grant is revoked by timeout.

Function
REQ-013 SHALL implement states IDLE, BUSY and GAP; all outputs SHALL be registered.
REQ-014 IDLE: if ena=1 and req!=0, SHALL select a winner and enter BUSY; the grant SHALL appear on the next edge (1-cycle latency).
REQ-015 Round-robin selection SHALL take the first set req bit found by searching ascending from ptr, wrapping 15->0.
REQ-016 Fixed-priority selection SHALL take the highest set req bit and ignore ptr.
REQ-017 BUSY: grant_valid=1, grant_idx and grant_onehot held constant, and hold counter incremented each cycle.
REQ-018 BUSY release SHALL occur when done=1, or when req[grant_idx]=0, or when the hold counter reaches MAX_HOLD.
REQ-019 On release SHALL enter GAP, clear grant_valid and grant_onehot, keep grant_idx, and set ptr = (grant_idx+1) mod 16 regardless of mode.
REQ-020 GAP SHALL last exactly 1 cycle, then go to IDLE; requests arriving during GAP SHALL be evaluated in IDLE.
REQ-021 Simultaneous done and timeout SHALL count as a normal release; timeout_flag SHALL NOT be set.
REQ-022 Timeout release (no done, req still high) SHALL set timeout_flag; only reset clears it.
REQ-023 done while in IDLE or GAP SHALL be ignored.
REQ-024 ena=0 during BUSY SHALL NOT revoke the active grant.
REQ-025 The hold counter SHALL be 8 bits and SHALL be cleared on entry to BUSY.
REQ-026 Back-to-back grants from one continuous request SHALL be separated by at least 2 cycles with grant_valid=0 (GAP then IDLE).

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, busy=0, timeout_flag=0, ptr=0 and hold counter=0.
REQ-028 Reset asserted mid-grant SHALL drop the grant asynchronously, and the first grant after reset SHALL use ptr=0.
REQ-029 The first arbitration SHALL occur on the first rising edge after rst_n is released with ena=1.

Verification
REQ-030 Round-robin rotation: prio_mode=0, req=0x0009, done pulsed each grant -> grant_idx sequence 0,3,0,3.
REQ-031 Fixed priority: prio_mode=1, req=0x8001 held, done pulsed each grant -> grant_idx is 15 every time.
REQ-032 Timeout: MAX_HOLD=4, req=0x0020 held, no done -> grant_valid high for 4 cycles, timeout_flag=1, next grant_idx=5 after GAP+IDLE.
REQ-033 Simultaneous events: done coincides with hold count reaching MAX_HOLD -> timeout_flag stays 0; ptr=grant_idx+1.
REQ-034 Wrap and gating: grant_idx=15 released with req=0x8002 and ena=0 -> no grant issued; after ena=1, grant_idx=1.
REQ-035 Reset mid-operation: rst_n pulsed low during BUSY -> all outputs 0 within the same cycle; req=0xFFFF afterwards -> grant_idx=0.
